// File: rtl/video_pattern_pkg.sv
// Shared constants, FSM state encoding and expected-pixel function for the quadrant video pattern.
// Used by both the pattern source and the pattern checker.
package video_pattern_pkg;

   localparam int unsigned VISIBLE_WIDTH  = 800;
   localparam int unsigned VISIBLE_HEIGHT = 600;
   localparam int unsigned FRAME_RATE     = 72;

   localparam logic [23:0] Q1_COLOR = 24'h00CC00;
   localparam logic [23:0] Q2_COLOR = 24'h00CCCC;
   localparam logic [23:0] Q3_COLOR = 24'hFF9A26;
   localparam logic [23:0] Q4_COLOR = 24'h9D26FF;

   typedef logic [1:0] state_t;
   localparam state_t StIdle   = 2'd0;
   localparam state_t StRun    = 2'd1;
   localparam state_t StReport = 2'd2;

   // phase 0 shows the inverted palette, phase 1 the true colours
   function automatic logic [23:0] expected_pixel(input logic [9:0] x, input logic [9:0] y,
                                                  input logic phase);
      logic [23:0] color;
      color = Q1_COLOR;
      case ({y[5], x[6]})
         2'b00:   color = Q1_COLOR;
         2'b01:   color = Q2_COLOR;
         2'b10:   color = Q3_COLOR;
         default: color = Q4_COLOR;
      endcase
      return phase ? color : ~color;
   endfunction

endpackage

// File: rtl/video_pattern_checker_if.sv
// Ready/valid 24-bit RGB video stream between the pattern source (master) and a sink (slave).
interface video_pattern_checker_if;
   logic        VideoValid;
   logic [23:0] Video;
   logic        VideoReady;

   modport master (output VideoValid, output Video, input VideoReady);
   modport slave  (input VideoValid, input Video, output VideoReady);
endinterface

// File: rtl/video_raster_counter.sv
// Raster position tracker: x/y/frame counters and inversion phase, advanced only on transfer.
module video_raster_counter #(
   parameter int unsigned VISIBLE_WIDTH  = video_pattern_pkg::VISIBLE_WIDTH,
   parameter int unsigned VISIBLE_HEIGHT = video_pattern_pkg::VISIBLE_HEIGHT,
   parameter int unsigned FRAME_RATE     = video_pattern_pkg::FRAME_RATE
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       xfer,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       eof,
   output logic       phase
);

   logic [9:0] x_q, x_d, y_q, y_d;
   logic [6:0] fcnt_q, fcnt_d;
   logic       phase_q, phase_d;
   logic       eol;

   assign eol = (x_q == 10'(VISIBLE_WIDTH - 1));
   assign eof = eol && (y_q == 10'(VISIBLE_HEIGHT - 1));

   always_comb begin
      x_d     = x_q;
      y_d     = y_q;
      fcnt_d  = fcnt_q;
      phase_d = phase_q;
      if (xfer) begin
         if (eol) begin
            x_d = '0;
            if (eof) begin
               y_d = '0;
               if (fcnt_q == 7'(FRAME_RATE - 1)) begin
                  fcnt_d  = '0;
                  phase_d = ~phase_q;
               end else begin
                  fcnt_d = fcnt_q + 7'd1;
               end
            end else begin
               y_d = y_q + 10'd1;
            end
         end else begin
            x_d = x_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         x_q     <= '0;
         y_q     <= '0;
         fcnt_q  <= '0;
         phase_q <= 1'b0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         fcnt_q  <= fcnt_d;
         phase_q <= phase_d;
      end
   end

   assign x     = x_q;
   assign y     = y_q;
   assign phase = phase_q;

endmodule

// File: rtl/video_pattern_checker.sv
// Sink-side checker for the quadrant video pattern; reports per-frame mismatch statistics.
// Define VIDEO_PATTERN_CHECKER_THROTTLE_EN to periodically drop VideoReady for backpressure tests.
module video_pattern_checker #(
   parameter int unsigned VISIBLE_WIDTH   = video_pattern_pkg::VISIBLE_WIDTH,
   parameter int unsigned VISIBLE_HEIGHT  = video_pattern_pkg::VISIBLE_HEIGHT,
`ifdef VIDEO_PATTERN_CHECKER_THROTTLE_EN
   parameter int unsigned THROTTLE_PERIOD = 16,
`endif
   parameter int unsigned FRAME_RATE      = video_pattern_pkg::FRAME_RATE
) (
   input  logic                    clock,
   input  logic                    reset,
   video_pattern_checker_if.slave  video,
   output logic                    frame_done,
   output logic [19:0]             frame_errors,
   output logic [9:0]              first_err_x,
   output logic [9:0]              first_err_y,
   output logic [15:0]             bad_frames,
   output logic                    phase
);

   import video_pattern_pkg::*;

   state_t      state_q, state_d;
   logic        ready, xfer, mismatch, eof, cur_phase, throttle;
   logic [9:0]  x, y;
   logic [19:0] err_cnt_q, err_cnt_d, errs_now;
   logic [9:0]  fx_q, fx_d, fy_q, fy_d, first_x, first_y;
   logic [19:0] pub_errs_q, pub_errs_d;
   logic [9:0]  pub_fx_q, pub_fx_d, pub_fy_q, pub_fy_d;
   logic [15:0] bad_q, bad_d;

`ifdef VIDEO_PATTERN_CHECKER_THROTTLE_EN
   localparam int unsigned ThrW = (THROTTLE_PERIOD > 1) ? $clog2(THROTTLE_PERIOD) : 1;
   logic [ThrW-1:0] thr_q;

   assign throttle = (thr_q == ThrW'(THROTTLE_PERIOD - 1));

   always_ff @(posedge clock) begin
      if (reset)         thr_q <= '0;
      else if (throttle) thr_q <= '0;
      else               thr_q <= thr_q + ThrW'(1);
   end
`else
   assign throttle = 1'b0;
`endif

   video_raster_counter #(
      .VISIBLE_WIDTH  (VISIBLE_WIDTH),
      .VISIBLE_HEIGHT (VISIBLE_HEIGHT),
      .FRAME_RATE     (FRAME_RATE)
   ) u_raster (
      .clock (clock),
      .reset (reset),
      .xfer  (xfer),
      .x     (x),
      .y     (y),
      .eof   (eof),
      .phase (cur_phase)
   );

   assign ready    = (state_q == StRun) && !throttle;
   assign xfer     = video.VideoValid && ready;
   assign mismatch = xfer && (video.Video != expected_pixel(x, y, cur_phase));
   assign errs_now = err_cnt_q + {19'd0, mismatch};
   assign first_x  = (mismatch && err_cnt_q == '0) ? x : fx_q;
   assign first_y  = (mismatch && err_cnt_q == '0) ? y : fy_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   state_d = StRun;
         StRun:    if (xfer && eof) state_d = StReport;
         StReport: state_d = StRun;
         default:  state_d = StIdle;
      endcase
   end

   // Results are loaded on the final transfer so they are already valid while frame_done is high,
   // and a mismatch on that last pixel lands in the published count.
   always_comb begin
      err_cnt_d  = errs_now;
      fx_d       = first_x;
      fy_d       = first_y;
      pub_errs_d = pub_errs_q;
      pub_fx_d   = pub_fx_q;
      pub_fy_d   = pub_fy_q;
      bad_d      = bad_q;
      if (xfer && eof) begin
         pub_errs_d = errs_now;
         pub_fx_d   = first_x;
         pub_fy_d   = first_y;
         if (errs_now != '0 && bad_q != 16'hFFFF) bad_d = bad_q + 16'd1;
         err_cnt_d  = '0;
         fx_d       = '0;
         fy_d       = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StIdle;
         err_cnt_q  <= '0;
         fx_q       <= '0;
         fy_q       <= '0;
         pub_errs_q <= '0;
         pub_fx_q   <= '0;
         pub_fy_q   <= '0;
         bad_q      <= '0;
      end else begin
         state_q    <= state_d;
         err_cnt_q  <= err_cnt_d;
         fx_q       <= fx_d;
         fy_q       <= fy_d;
         pub_errs_q <= pub_errs_d;
         pub_fx_q   <= pub_fx_d;
         pub_fy_q   <= pub_fy_d;
         bad_q      <= bad_d;
      end
   end

   assign video.VideoReady = ready;
   assign frame_done       = (state_q == StReport);
   assign frame_errors     = pub_errs_q;
   assign first_err_x      = pub_fx_q;
   assign first_err_y      = pub_fy_q;
   assign bad_frames       = bad_q;
   assign phase            = cur_phase;

endmodule
